// File: rtl/pkg_uart.sv
// Shared UART definitions: baud counter width, frame size and receiver FSM states.
package pkg_uart;

  localparam int unsigned BW        = 16;
  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } rx_state_t;

endpackage

// File: rtl/baudgen_rx.sv
// Loadable baud down-counter; tick marks the cycle in which the count reads zero.
module baudgen_rx
  import pkg_uart::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [BW-1:0] load_val_i,
  input  logic          run_i,
  output logic          tick_o
);

  logic [BW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (run_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - BW'(1);
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM, registered strobes.
module uart_rx
  import pkg_uart::*;
#(
  parameter int unsigned BAUDRATE = 434
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_out_o,
  output logic                 data_valid_o,
  output logic                 frame_err_o,
  output logic                 busy_o
);

  localparam int unsigned   HALF     = BAUDRATE / 2;
  localparam logic [BW-1:0] HalfLoad = BW'(HALF - 1);
  localparam logic [BW-1:0] BitLoad  = BW'(BAUDRATE - 1);

  logic [1:0]           sync_q;
  logic                 rx_s;
  rx_state_t            state_q;
  logic [2:0]           bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;
  logic                 tick;
  logic                 load;
  logic                 run;
  logic [BW-1:0]        load_val;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_i};
    end
  end

  assign rx_s = sync_q[1];

  // Counter control must act in the same cycle the FSM decides, so it is decoded combinationally.
  always_comb begin
    load     = 1'b0;
    load_val = BitLoad;
    unique case (state_q)
      StIdle: begin
        load     = !rx_s;
        load_val = HalfLoad;
      end
      StStart: load = tick && !rx_s;
      StData:  load = tick;
      default: load = 1'b0;
    endcase
  end

  assign run = (state_q != StIdle) && (state_q != StWaitIdle);

  baudgen_rx u_baudgen (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .load_val_i (load_val),
    .run_i      (run),
    .tick_o     (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!rx_s) state_q <= StStart;
        end
        StStart: begin
          if (tick) begin
            bit_idx_q <= '0;
            state_q   <= rx_s ? StIdle : StData;
          end
        end
        StData: begin
          if (tick) begin
            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_idx_q == 3'(DATA_BITS - 1)) begin
              state_q <= StStop;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
        StStop: begin
          if (tick) begin
            if (rx_s) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= StIdle;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= StWaitIdle;
            end
          end
        end
        StWaitIdle: begin
          // A held-low line (break) must not restart decoding until it returns high.
          if (rx_s) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign data_out_o   = data_q;
  assign data_valid_o = valid_q;
  assign frame_err_o  = ferr_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized bench for uart_rx at BAUDRATE=16 against a frame-level timing model.
module tb_uart_rx;

  localparam int B    = 16;
  localparam int HALF = B / 2;
  localparam int HIST = 16384;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] data;
  } ev_t;

  ev_t        obs_q[$];
  ev_t        exp_q[$];
  ev_t        mon_e;
  logic       busy_h[HIST];
  logic [7:0] last_good;

  uart_rx #(
    .BAUDRATE (B)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_i         (rx),
    .data_out_o   (data_out),
    .data_valid_o (data_valid),
    .frame_err_o  (frame_err),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // cyc equals the index of the edge just taken when sampled 1 time unit later.
  always @(posedge clk) begin
    #1;
    if (cyc < HIST) busy_h[cyc] = busy;
    if (data_valid === 1'b1) begin
      mon_e.cyc = cyc; mon_e.kind = 0; mon_e.data = data_out;
      obs_q.push_back(mon_e);
    end
    if (frame_err === 1'b1) begin
      mon_e.cyc = cyc; mon_e.kind = 1; mon_e.data = data_out;
      obs_q.push_back(mon_e);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_busy(input string tag, input int n, input logic expv);
    if (n >= 0 && n < HIST) chk(tag, 32'(busy_h[n]), 32'(expv));
    else chk(tag, 32'hdead_beef, 32'(expv));
  endtask

  // Must be called at a falling clock edge; p is the first rising edge that sees the start bit.
  task automatic send_frame(input logic [7:0] d, input logic stop, output int p);
    p  = cyc + 1;
    rx = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (B) @(negedge clk);
    end
    rx = stop;
    repeat (B) @(negedge clk);
  endtask

  // Two sync edges, half a bit to the start midpoint, nine more bits to the stop midpoint.
  task automatic expect_frame(input int p, input logic [7:0] d, input logic stop);
    ev_t e;
    e.cyc = p + 2 + HALF + 9 * B;
    if (stop) begin
      e.kind    = 0;
      e.data    = d;
      last_good = d;
    end else begin
      e.kind = 1;
      e.data = last_good;
    end
    exp_q.push_back(e);
  endtask

  task automatic cmp_events(input string tag);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk({tag, "_cyc"}, obs_q[i].cyc, exp_q[i].cyc);
      chk({tag, "_kind"}, obs_q[i].kind, exp_q[i].kind);
      chk({tag, "_data"}, 32'(obs_q[i].data), 32'(exp_q[i].data));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int         p, p1, p2, r, gap;
    logic [7:0] d;
    logic [7:0] d55;
    logic       s;

    rst       = 1'b0;
    rx        = 1'b1;
    last_good = 8'h00;
    d55       = 8'h55;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_valid", 32'(data_valid), 32'h0);
    chk("rst_ferr", 32'(frame_err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (200) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'h0);
    cmp_events("idle");

    send_frame(8'hA5, 1'b1, p);
    expect_frame(p, 8'hA5, 1'b1);
    repeat (20) @(negedge clk);
    cmp_events("single");
    chk("single_data", 32'(data_out), 32'hA5);
    chk_busy("single_busy_pre", p + 1, 1'b0);
    chk_busy("single_busy_c1", p + 2, 1'b1);
    chk_busy("single_busy_last", p + 153, 1'b1);
    chk_busy("single_busy_end", p + 154, 1'b0);

    p  = cyc + 1;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    cmp_events("glitch");
    chk_busy("glitch_busy_c1", p + 2, 1'b1);
    chk_busy("glitch_busy_c8", p + 9, 1'b1);
    chk_busy("glitch_busy_c9", p + 10, 1'b0);

    send_frame(8'h3C, 1'b0, p);
    expect_frame(p, 8'h3C, 1'b0);
    repeat (40) @(negedge clk);
    r  = cyc + 1;
    rx = 1'b1;
    repeat (20) @(negedge clk);
    cmp_events("ferr");
    chk("ferr_data_hold", 32'(data_out), 32'hA5);
    chk_busy("ferr_busy_stop", p + 154, 1'b1);
    chk_busy("ferr_busy_break", p + 180, 1'b1);
    chk_busy("ferr_busy_rise", r + 1, 1'b1);
    chk_busy("ferr_busy_idle", r + 2, 1'b0);

    send_frame(8'h00, 1'b1, p1);
    expect_frame(p1, 8'h00, 1'b1);
    send_frame(8'hFF, 1'b1, p2);
    expect_frame(p2, 8'hFF, 1'b1);
    repeat (20) @(negedge clk);
    if (obs_q.size() == 2) chk("b2b_gap", obs_q[1].cyc - obs_q[0].cyc, 160);
    else chk("b2b_pulses", obs_q.size(), 2);
    cmp_events("b2b");

    rx = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = d55[i];
      repeat (B) @(negedge clk);
    end
    rx = d55[3];
    repeat (HALF) @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    @(posedge clk);
    #1;
    chk("rstmid_busy", 32'(busy), 32'h0);
    chk("rstmid_valid", 32'(data_valid), 32'h0);
    chk("rstmid_ferr", 32'(frame_err), 32'h0);
    chk("rstmid_data", 32'(data_out), 32'h0);
    last_good = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    cmp_events("rstmid");
    send_frame(8'h81, 1'b1, p);
    expect_frame(p, 8'h81, 1'b1);
    repeat (20) @(negedge clk);
    cmp_events("after_rst");
    chk("after_rst_data", 32'(data_out), 32'h81);

    for (int n = 0; n < 24; n++) begin
      d = 8'($urandom_range(0, 255));
      s = ($urandom_range(0, 5) != 0);
      send_frame(d, s, p);
      expect_frame(p, d, s);
      gap = s ? int'($urandom_range(0, 20)) : int'($urandom_range(4, 24));
      rx  = 1'b1;
      repeat (gap) @(negedge clk);
    end
    rx = 1'b1;
    repeat (30) @(negedge clk);
    cmp_events("random");
    chk("final_data", 32'(data_out), 32'(last_good));
    chk("final_busy", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: recovers 8N1 bytes from the asynchronous `rx` pin and presents each byte with a one-cycle valid strobe. It is the receive-side counterpart of the transmit path and shares `pkg_uart` with it. A two-flop synchronizer feeds a state machine that samples each bit at its midpoint. A mid-bit baud tick generator drives the sampling.

## Interface
- `BAUDRATE`, default 434 (50 MHz / 115200, truncated): clock cycles per bit. Must be ≥ 4.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-low.
- `rx`  in  1  serial line, asynchronous to `clk`, idle high.
- `data_out`  out  8  last correctly framed byte. Holds its value until the next valid byte.
- `data_valid`  out  1  one-cycle pulse: `data_out` is newly updated.
- `frame_err`  out  1  one-cycle pulse: stop bit was sampled low.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- **Synchronizer:** two flops, both reset to 1. `rx_s` is the output of the second flop. All logic uses `rx_s` only.
- **Constants:** HALF = BAUDRATE/2 (integer division). The baud counter is BW bits wide, with BW from `pkg_uart`.
- **States:** IDLE, START, DATA, STOP, WAIT_IDLE.
- **IDLE:** when `rx_s`=0, load the counter with HALF-1 and go to START.
- **START:** at the counter tick, sample `rx_s`.
  - 0: reload BAUDRATE-1, bit index = 0, go to DATA.
  - 1: false start, return to IDLE with no output.
- **DATA:** at each tick, shift `rx_s` into the shift register LSB-first (shift right, insert at bit 7) and reload BAUDRATE-1.
  - After bit index 7, go to STOP.
  - Otherwise increment the bit index (3 bits).
- **STOP:** at the tick, sample `rx_s`.
  - 1: `data_out` <= shift register, pulse `data_valid`, go to IDLE.
  - 0: pulse `frame_err`, leave `data_out` unchanged, go to WAIT_IDLE.
- **WAIT_IDLE:** stay until `rx_s`=1, then go to IDLE. This prevents a break condition from being decoded as repeated 0x00 frames.
- **Tick:** the tick is the cycle in which the counter equals 0. The counter decrements otherwise and is only active outside IDLE and WAIT_IDLE.
- **Reset values:** `data_out`=0, `data_valid`=0, `frame_err`=0, `busy`=0, state IDLE, counter 0, sync flops 1.
- **Reset mid-frame:** returns to IDLE immediately and produces no pulse. A frame already in progress on the line may be decoded partially as a new start. That is acceptable because the next true start re-aligns.

## Timing
- Cycle 0 is the first clock edge at which `rx_s` is seen low. `rx_s` lags `rx` by 2 cycles.
- Start-bit sample: cycle HALF.
- Data bit i (i = 0..7) sample: cycle HALF + (i+1)·BAUDRATE.
- Stop-bit sample: cycle HALF + 9·BAUDRATE. For BAUDRATE=434 this is cycle 4123.
- `data_valid` / `frame_err` are registered: high for exactly the one cycle after the stop-sample edge.
- `busy` is high from cycle 1 until the cycle in which the state returns to IDLE.
- **Back-to-back frames:** the FSM re-enters IDLE mid-stop-bit, so a start edge arriving BAUDRATE/2 cycles later is caught. No inter-frame gap beyond the stop bit is required.
- **Clock mismatch:** the receiver tolerates ±(HALF-1)/(9.5·BAUDRATE) accumulated skew, about ±5% at the default BAUDRATE.

## Structure
- `pkg_uart` holds:
  - `BW` (counter width; must hold BAUDRATE-1)
  - `DATA_BITS` = 8
  - the FSM state enum typedef `rx_state_t`
- Sub-module `baudgen_rx`: a loadable down-counter with inputs `clk`, `rst`, `load`, `load_val`, `run` and output `tick`. The FSM drives `load_val` (HALF-1 or BAUDRATE-1).
- FSM, shift register, synchronizer and output registers live in `uart_rx`.

## Test plan
Use BAUDRATE=16 (HALF=8) unless noted.
- **Reset:** hold `rst`=0 for 3 cycles with `rx`=1. Expect all outputs 0 and `busy`=0, and no pulses for 200 idle cycles.
- **Single byte:** send 0xA5 (start, 1,0,1,0,0,1,0,1, stop). Expect `data_out`=0xA5, `data_valid` high for 1 cycle at cycle 8+9·16+1 = 153 after `rx_s` falls, and `frame_err`=0.
- **Glitch:** drive `rx` low for 4 cycles, then high. Expect no `data_valid`, no `frame_err`, and `busy` to return to 0 by cycle 9.
- **Framing error:** send 0x3C with the stop bit 0, then hold `rx` low for 40 cycles. Expect one `frame_err` pulse, no `data_valid`, `data_out` unchanged, and `busy`=1 until `rx_s` goes high.
- **Back-to-back:** send 0x00 then 0xFF with no idle gap. Expect two `data_valid` pulses 160 cycles apart, with `data_out` = 0x00 then 0xFF.
- **Reset mid-frame:** assert `rst` during data bit 3 of 0x55. Expect no pulse and the state IDLE. A following 0x81 frame is received correctly.
